// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: default widths and wr_sel encoding for pwm_bank
package pwm_bank_pkg;
  localparam int NCH_DEF = 8;
  localparam int CW_DEF = 28;
  localparam logic SEL_PERIOD = 1'b0;
  localparam logic SEL_DUTY = 1'b1;
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one PWM channel with shadow/active period and duty registers
module pwm_chan import pwm_bank_pkg::*; #(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wr_per,
  input  logic          wr_duty,
  input  logic [CW-1:0] wr_data,
  output logic          pwm,
  output logic          wrap
);
  logic [CW-1:0] per_s, duty_s, per_a, duty_a, cnt;
  logic run, last;
  always_comb begin
    run = en && per_a != '0;
    last = run && cnt == per_a - CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      per_s <= '0;
      duty_s <= '0;
      per_a <= '0;
      duty_a <= '0;
      cnt <= '0;
      pwm <= 1'b0;
      wrap <= 1'b0;
    end else begin
      if (wr_per) per_s <= wr_data;
      if (wr_duty) duty_s <= wr_data;
      // active values reload from the pre-write shadows while idle or at a wrap
      if (!run || last) begin
        per_a <= per_s;
        duty_a <= duty_s;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
      pwm <= run && cnt < duty_a;
      wrap <= last;
    end
  end
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: NCH-channel PWM bank with write decode; PWM_BANK_IRQ_EN adds sticky wrap interrupts
module pwm_bank import pwm_bank_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                               clk_clk,
  input  logic                               reset_reset,
  input  logic                               wr_en,
  input  logic [(NCH>1?$clog2(NCH):1)-1:0]   wr_ch,
  input  logic                               wr_sel,
  input  logic [CW-1:0]                      wr_data,
  input  logic [NCH-1:0]                     ch_en,
  output logic [NCH-1:0]                     pwm_out,
  output logic [NCH-1:0]                     wrap
`ifdef PWM_BANK_IRQ_EN
  ,
  input  logic [NCH-1:0]                     irq_clr,
  output logic [NCH-1:0]                     irq
`endif
);
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
  logic [NCH-1:0] hit;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hit[i] = wr_en && !reset_reset && wr_ch == CHW'(i);
    pwm_chan #(.CW(CW)) u_chan (
      .clk(clk_clk),
      .rst(reset_reset),
      .en(ch_en[i]),
      .wr_per(hit[i] && wr_sel == SEL_PERIOD),
      .wr_duty(hit[i] && wr_sel == SEL_DUTY),
      .wr_data(wr_data),
      .pwm(pwm_out[i]),
      .wrap(wrap[i])
    );
  end
`ifdef PWM_BANK_IRQ_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) irq <= '0;
    else irq <= (irq & ~irq_clr) | wrap;
  end
`endif
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed self-checking bench for pwm_bank (default parameters)
module tb_pwm_bank;
  import pwm_bank_pkg::*;
  localparam int NCH = 8;
  localparam int CW = 28;
  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  logic wr_en = 1'b0;
  logic [2:0] wr_ch = '0;
  logic wr_sel = 1'b0;
  logic [CW-1:0] wr_data = '0;
  logic [NCH-1:0] ch_en = '0;
  logic [NCH-1:0] pwm_out, wrap;
`ifdef PWM_BANK_IRQ_EN
  logic [NCH-1:0] irq_clr = '0;
  logic [NCH-1:0] irq;
`endif
  int n_chk = 0;
  int n_fail = 0;

  pwm_bank #(.NCH(NCH), .CW(CW)) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_sel(wr_sel),
    .wr_data(wr_data),
    .ch_en(ch_en),
    .pwm_out(pwm_out),
    .wrap(wrap)
`ifdef PWM_BANK_IRQ_EN
    ,
    .irq_clr(irq_clr),
    .irq(irq)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  task automatic step;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input logic sel, input int data);
    wr_en = 1'b1;
    wr_ch = 3'(ch);
    wr_sel = sel;
    wr_data = CW'(data);
    step;
    wr_en = 1'b0;
  endtask

  task automatic setup(input int ch, input int per, input int duty);
    wr(ch, SEL_PERIOD, per);
    wr(ch, SEL_DUTY, duty);
    step;
  endtask

  initial begin
    step;
    step;
    check("reset pwm_out", 32'(pwm_out), 32'h0);
    check("reset wrap", 32'(wrap), 32'h0);
`ifdef PWM_BANK_IRQ_EN
    check("reset irq", 32'(irq), 32'h0);
`endif
    reset_reset = 1'b0;
    // ch0: per 4, duty 1 -> 1,0,0,0 with wrap on the last cycle
    setup(0, 4, 1);
    check("ch0 idle pwm", 32'(pwm_out[0]), 32'h0);
    ch_en[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step;
      check("ch0 pwm", 32'(pwm_out[0]), 32'(k % 4 == 0));
      check("ch0 wrap", 32'(wrap[0]), 32'(k % 4 == 3));
    end
    ch_en[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step;
      check("ch0 disabled pwm", 32'(pwm_out[0]), 32'h0);
      check("ch0 disabled wrap", 32'(wrap[0]), 32'h0);
    end
    // ch1: per 5 duty 0 constant low, duty 7 constant high after next wrap
    setup(1, 5, 0);
    ch_en[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step;
      check("ch1 low pwm", 32'(pwm_out[1]), 32'h0);
      check("ch1 low wrap", 32'(wrap[1]), 32'(k == 4));
    end
    wr(1, SEL_DUTY, 7);
    check("ch1 write pwm", 32'(pwm_out[1]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step;
      check("ch1 pending pwm", 32'(pwm_out[1]), 32'h0);
      check("ch1 pending wrap", 32'(wrap[1]), 32'(k == 3));
    end
    for (int k = 0; k < 10; k++) begin
      step;
      check("ch1 high pwm", 32'(pwm_out[1]), 32'h1);
    end
    // ch2: per 8 duty 4, duty 2 written at cnt 3
    setup(2, 8, 4);
    ch_en[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      check("ch2 first pwm", 32'(pwm_out[2]), 32'h1);
    end
    wr(2, SEL_DUTY, 2);
    check("ch2 at write pwm", 32'(pwm_out[2]), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step;
      check("ch2 tail pwm", 32'(pwm_out[2]), 32'h0);
      check("ch2 tail wrap", 32'(wrap[2]), 32'(k == 3));
    end
    for (int k = 0; k < 8; k++) begin
      step;
      check("ch2 next pwm", 32'(pwm_out[2]), 32'(k < 2));
      check("ch2 next wrap", 32'(wrap[2]), 32'(k == 7));
    end
    // ch3: per 6 written in the wrap cycle of per 3
    setup(3, 3, 1);
    ch_en[3] = 1'b1;
    step;
    step;
    wr(3, SEL_PERIOD, 6);
    check("ch3 wrap at write", 32'(wrap[3]), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step;
      check("ch3 old pwm", 32'(pwm_out[3]), 32'(k == 0));
      check("ch3 old wrap", 32'(wrap[3]), 32'(k == 2));
    end
    for (int k = 0; k < 12; k++) begin
      step;
      check("ch3 new pwm", 32'(pwm_out[3]), 32'(k % 6 == 0));
      check("ch3 new wrap", 32'(wrap[3]), 32'(k % 6 == 5));
    end
    // ch4: reset at cnt 5 of per 10, with a write to ch5 during reset
    setup(4, 10, 5);
    ch_en[4] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step;
      check("ch4 pwm", 32'(pwm_out[4]), 32'h1);
    end
    reset_reset = 1'b1;
    wr_en = 1'b1;
    wr_ch = 3'd5;
    wr_sel = SEL_PERIOD;
    wr_data = CW'(2);
    ch_en[5] = 1'b1;
    step;
    reset_reset = 1'b0;
    wr_en = 1'b0;
    check("mid reset pwm_out", 32'(pwm_out), 32'h0);
    check("mid reset wrap", 32'(wrap), 32'h0);
    for (int k = 0; k < 12; k++) begin
      step;
      check("post reset pwm_out", 32'(pwm_out), 32'h0);
      check("post reset wrap", 32'(wrap), 32'h0);
    end
`ifdef PWM_BANK_IRQ_EN
    // ch6: irq set on wrap wins over a simultaneous clear
    setup(6, 3, 0);
    ch_en[6] = 1'b1;
    step;
    step;
    step;
    check("irq wrap", 32'(wrap[6]), 32'h1);
    check("irq before set", 32'(irq[6]), 32'h0);
    irq_clr[6] = 1'b1;
    step;
    check("irq set wins", 32'(irq[6]), 32'h1);
    step;
    check("irq cleared", 32'(irq[6]), 32'h0);
    irq_clr[6] = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
- REQ-001 The block SHALL have parameter NCH, default 8: number of independent PWM channels, range 1..16.
- REQ-002 The block SHALL have parameter CW, default 28: counter, period and duty width in bits, range 8..32.
- REQ-003 The block SHALL have port clk_clk, input, 1 bit: the single clock; all logic is on the rising edge.
- REQ-004 The block SHALL have port reset_reset, input, 1 bit: reset, synchronous and active-high.
- REQ-005 The block SHALL have port wr_en, input, 1 bit: write strobe for one shadow register.
- REQ-006 The block SHALL have port wr_ch, input, $clog2(NCH) bits (min 1): target channel.
- REQ-007 The block SHALL have port wr_sel, input, 1 bit: 0 selects the period shadow, 1 selects the duty shadow.
- REQ-008 The block SHALL have port wr_data, input, CW bits: value to write.
- REQ-009 The block SHALL have port ch_en, input, NCH bits: per-channel run enable.
- REQ-010 The block SHALL have port pwm_out, output, NCH bits: registered PWM outputs.
- REQ-011 The block SHALL have port wrap, output, NCH bits: registered one-cycle pulse per channel at period end.

Function
- REQ-012 Each channel SHALL hold the registers per_s, duty_s (shadow), per_a, duty_a (active) and cnt, each CW bits.
- REQ-013 A write SHALL update the selected shadow register on the edge where wr_en=1; wr_ch>=NCH SHALL be ignored.
- REQ-014 A channel SHALL be "running" when ch_en[i]=1 and per_a!=0; otherwise it is "idle".
- REQ-015 While idle: cnt<=0, per_a<=per_s and duty_a<=duty_s every cycle, pwm_out[i]<=0, wrap[i]<=0.
- REQ-016 While running and cnt!=per_a-1: cnt<=cnt+1.
- REQ-017 While running and cnt==per_a-1, the channel SHALL perform a wrap: cnt<=0, per_a<=per_s, duty_a<=duty_s, wrap[i]<=1.
- REQ-018 While running, pwm_out[i] SHALL be loaded with (cnt<duty_a), giving a 1-cycle latency from cnt to pwm_out.
- REQ-019 duty_a=0 SHALL give constant low; duty_a>=per_a SHALL give constant high; period length SHALL be per_a cycles.
- REQ-020 If a shadow write and a wrap occur in the same cycle, the wrap SHALL load the pre-write shadow value; the new value takes effect at the next wrap.
- REQ-021 When ch_en[i] falls mid-period, the channel SHALL go idle on the next edge with no partial wrap pulse.
- REQ-022 When ch_en[i] rises, counting SHALL start from cnt=0 using the shadow values captured during the idle phase.
- REQ-023 Channels SHALL be fully independent; no arithmetic SHALL overflow CW bits (per_a-1 is evaluated only when per_a!=0).

Reset
- REQ-024 On reset_reset=1 at an edge, all shadow, active and cnt registers, pwm_out and wrap SHALL become 0, including mid-period.
- REQ-025 A write SHALL be ignored in any cycle where reset_reset=1.

Configuration
- REQ-026 When macro PWM_BANK_IRQ_EN is defined, the block SHALL add input irq_clr (NCH bits) and output irq (NCH bits).
- REQ-027 With PWM_BANK_IRQ_EN, irq[i] SHALL be set on a wrap and cleared by irq_clr[i]; set SHALL win if both occur in one cycle; reset value is 0.
- REQ-028 Without PWM_BANK_IRQ_EN, the ports irq and irq_clr and their logic SHALL be absent, with all other behaviour unchanged.

Structure
- REQ-029 Package pwm_bank_pkg SHALL hold the default CW and NCH constants and the wr_sel encoding constants SEL_PERIOD=0 and SEL_DUTY=1.
- REQ-030 Per-channel logic SHALL live in sub-module pwm_chan, instantiated NCH times by a generate loop; pwm_bank SHALL hold only write decode and the optional IRQ logic.

Verification
- REQ-031 ch0: per=4, duty=1, en=1 -> pwm_out[0] pattern 1,0,0,0 repeating; wrap[0] pulses every 4 cycles.
- REQ-032 ch1: per=5, duty=0, then duty=7 -> constant low, then constant high after the next wrap.
- REQ-033 ch2 running per=8 duty=4: write duty=2 at cnt=3 -> current period stays 4 high; next period is 2 high.
- REQ-034 Write per=6 in the exact wrap cycle of per=3 -> one more 3-cycle period, then 6-cycle periods.
- REQ-035 Assert reset at cnt=5 of per=10 -> next cycle all outputs 0, shadows 0, channel idle until rewritten.
- REQ-036 With PWM_BANK_IRQ_EN, per=3 and irq_clr asserted in a wrap cycle -> irq stays 1; irq_clr next cycle -> irq=0.
